// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle fetch/decode/execute sequencer for the
// 16-register datapath. It owns the PC, the instruction register and the
// condition-flag register, and it drives the datapath control word
// combinationally from the current state and the IR.
module datapath_ctrl #(
    parameter logic [3:0] OP_PASSB = 4'hF,
    parameter int         PC_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            halted,
    output logic [PC_W-1:0] pc,
    output logic            instr_req,
    input  logic            instr_ack,
    input  logic [15:0]     instr_in,
    output logic            mem_rd,
    output logic            mem_wr,
    input  logic            mem_ack,
    output logic [15:0]     mem_addr,
    output logic [15:0]     mem_wdata,
    input  logic [15:0]     mem_rdata,
    input  logic [15:0]     a_out,
    input  logic [15:0]     b_out,
    input  logic            v,
    input  logic            c,
    input  logic            n,
    input  logic            z,
    output logic [3:0]      dest_sel,
    output logic [3:0]      a_sel,
    output logic [3:0]      b_sel,
    output logic [3:0]      op_sel,
    output logic [15:0]     const_out,
    output logic            const_sel,
    output logic            data_sel,
    output logic            load_en
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [3:0] OPC_LDI  = 4'hA;
    localparam logic [3:0] OPC_LD   = 4'hB;
    localparam logic [3:0] OPC_ST   = 4'hC;
    localparam logic [3:0] OPC_BR   = 4'hD;
    localparam logic [3:0] OPC_JMP  = 4'hE;
    localparam logic [3:0] OPC_HALT = 4'hF;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [3:0]      flags_q, flags_d;   // {v, c, n, z}

    logic [3:0]      ir_op, ir_dr, ir_sa, ir_sb;
    logic [7:0]      ir_imm8;
    logic [PC_W-1:0] br_off;
    logic            br_taken;

    assign ir_op   = ir_q[15:12];
    assign ir_dr   = ir_q[11:8];
    assign ir_sa   = ir_q[7:4];
    assign ir_sb   = ir_q[3:0];
    assign ir_imm8 = ir_q[7:0];
    assign br_off  = {{(PC_W-8){ir_imm8[7]}}, ir_imm8};

    // Data port always addresses through A and writes from B.
    assign mem_addr  = a_out;
    assign mem_wdata = b_out;
    assign pc        = pc_q;
    // mem_rdata reaches the register file through the datapath's data input;
    // this block only asserts data_sel to steer it.

    // Branch condition evaluated against the latched flags, never the live ones.
    always_comb begin
        br_taken = 1'b0;
        case (ir_dr)
            4'd0:    br_taken = 1'b1;
            4'd1:    br_taken = flags_q[0];
            4'd2:    br_taken = flags_q[1];
            4'd3:    br_taken = flags_q[2];
            4'd4:    br_taken = flags_q[3];
            4'd5:    br_taken = ~flags_q[0];
            default: br_taken = 1'b0;
        endcase
    end

    // State, PC, IR and flag registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    // Next-state logic and the combinational control word.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        flags_d   = flags_q;
        halted    = 1'b0;
        instr_req = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        dest_sel  = 4'd0;
        a_sel     = 4'd0;
        b_sel     = 4'd0;
        op_sel    = 4'd0;
        const_out = 16'd0;
        const_sel = 1'b0;
        data_sel  = 1'b0;
        load_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_ack) begin
                    ir_d    = instr_in;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (ir_op)
                    OPC_LDI: begin
                        const_out = {8'h00, ir_imm8};
                        const_sel = 1'b1;
                        op_sel    = OP_PASSB;
                        dest_sel  = ir_dr;
                        load_en   = 1'b1;
                    end
                    OPC_LD: begin
                        a_sel   = ir_sa;
                        state_d = S_MEM;
                    end
                    OPC_ST: begin
                        a_sel   = ir_sa;
                        b_sel   = ir_sb;
                        state_d = S_MEM;
                    end
                    OPC_BR: begin
                        // pc already points past the branch here
                        if (br_taken) pc_d = pc_q + br_off;
                    end
                    OPC_JMP: begin
                        a_sel = ir_sa;
                        pc_d  = a_out[PC_W-1:0];
                    end
                    OPC_HALT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        // ALU ops 0x0..0x9 write the result and capture flags
                        op_sel   = ir_op;
                        a_sel    = ir_sa;
                        b_sel    = ir_sb;
                        dest_sel = ir_dr;
                        load_en  = 1'b1;
                        flags_d  = {v, c, n, z};
                    end
                endcase
            end
            S_MEM: begin
                a_sel = ir_sa;
                if (ir_op == OPC_LD) begin
                    mem_rd = 1'b1;
                    op_sel = OP_PASSB;
                    if (mem_ack) begin
                        data_sel = 1'b1;
                        dest_sel = ir_dr;
                        load_en  = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else begin
                    b_sel  = ir_sb;
                    mem_wr = 1'b1;
                    if (mem_ack) state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: the stimulus thread pushes expected
// fetch/register-write/store events, a negedge monitor pops and compares.
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halted;
    logic [15:0] pc;
    logic        instr_req;
    logic        instr_ack;
    logic [15:0] instr_in;
    logic        mem_rd, mem_wr, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] a_out, b_out;
    logic        v, c, n, z;
    logic [3:0]  dest_sel, a_sel, b_sel, op_sel;
    logic [15:0] const_out;
    logic        const_sel, data_sel, load_en;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  kind;      // 0 fetch, 1 register write, 2 store
        logic [15:0] pc;
        logic [3:0]  dest;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  op;
        logic        cs;
        logic [15:0] co;
        logic        ds;
        logic        ack;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        chk_ab;
    } ev_t;

    ev_t exp_q[$];

    datapath_ctrl #(.OP_PASSB(4'hF), .PC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halted(halted), .pc(pc),
        .instr_req(instr_req), .instr_ack(instr_ack), .instr_in(instr_in),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .a_out(a_out), .b_out(b_out), .v(v), .c(c), .n(n), .z(z),
        .dest_sel(dest_sel), .a_sel(a_sel), .b_sel(b_sel), .op_sel(op_sel),
        .const_out(const_out), .const_sel(const_sel), .data_sel(data_sel),
        .load_en(load_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    function automatic ev_t blank_ev();
        ev_t e;
        e = '0;
        return e;
    endfunction

    task automatic push_fetch(input logic [15:0] p);
        ev_t e = blank_ev();
        e.kind = 2'd0; e.pc = p;
        exp_q.push_back(e);
    endtask

    task automatic push_write(input logic [3:0] d, input logic [3:0] op, input logic cs,
                              input logic [15:0] co, input logic ds, input logic ack,
                              input logic chk, input logic [3:0] a, input logic [3:0] b);
        ev_t e = blank_ev();
        e.kind = 2'd1; e.dest = d; e.op = op; e.cs = cs; e.co = co; e.ds = ds;
        e.ack = ack; e.chk_ab = chk; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic push_store(input logic [3:0] a, input logic [3:0] b,
                              input logic [15:0] addr, input logic [15:0] wd);
        ev_t e = blank_ev();
        e.kind = 2'd2; e.a = a; e.b = b; e.addr = addr; e.wdata = wd; e.chk_ab = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: one line per observed transaction, compared against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            ev_t o, e;
            logic hit;
            o = blank_ev();
            hit = 1'b0;
            if (instr_req && instr_ack) begin
                hit = 1'b1; o.kind = 2'd0; o.pc = pc;
            end else if (load_en) begin
                hit = 1'b1; o.kind = 2'd1; o.dest = dest_sel; o.op = op_sel;
                o.cs = const_sel; o.co = const_out; o.ds = data_sel; o.ack = mem_ack;
                o.a = a_sel; o.b = b_sel;
            end else if (mem_wr && mem_ack) begin
                hit = 1'b1; o.kind = 2'd2; o.a = a_sel; o.b = b_sel;
                o.addr = mem_addr; o.wdata = mem_wdata;
            end
            if (hit) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got kind %0d with nothing expected", o.kind);
                end else begin
                    e = exp_q.pop_front();
                    if (o.kind != e.kind) begin
                        errors++;
                        $display("FAIL event_kind: got %0d required %0d", o.kind, e.kind);
                    end else if (e.kind == 2'd0) begin
                        if (o.pc !== e.pc) begin
                            errors++;
                            $display("FAIL fetch_pc: got %h required %h", o.pc, e.pc);
                        end else $display("ok   fetch pc=%h", o.pc);
                    end else if (e.kind == 2'd1) begin
                        if (o.dest !== e.dest || o.op !== e.op || o.cs !== e.cs || o.co !== e.co ||
                            o.ds !== e.ds || o.ack !== e.ack ||
                            (e.chk_ab && (o.a !== e.a || o.b !== e.b))) begin
                            errors++;
                            $display("FAIL reg_write: got d=%h op=%h cs=%b co=%h ds=%b ack=%b a=%h b=%h required d=%h op=%h cs=%b co=%h ds=%b ack=%b a=%h b=%h",
                                     o.dest, o.op, o.cs, o.co, o.ds, o.ack, o.a, o.b,
                                     e.dest, e.op, e.cs, e.co, e.ds, e.ack, e.a, e.b);
                        end else $display("ok   write d=%h op=%h co=%h ds=%b", o.dest, o.op, o.co, o.ds);
                    end else begin
                        if (o.a !== e.a || o.b !== e.b || o.addr !== e.addr || o.wdata !== e.wdata) begin
                            errors++;
                            $display("FAIL store: got a=%h b=%h addr=%h wd=%h required a=%h b=%h addr=%h wd=%h",
                                     o.a, o.b, o.addr, o.wdata, e.a, e.b, e.addr, e.wdata);
                        end else $display("ok   store addr=%h wd=%h", o.addr, o.wdata);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a fetch request, optionally delays the ack and injects a stray mem_ack.
    task automatic do_fetch(input logic [15:0] ins, input int dly, input logic spur);
        int k = 0;
        while (!instr_req && k < 50) begin
            tick();
            k++;
        end
        if (!instr_req) begin
            checks++; errors++;
            $display("FAIL fetch_timeout: instr_req never rose");
        end
        for (int i = 0; i < dly; i++) begin
            mem_ack = spur && (i == 0);
            tick();
        end
        mem_ack   = 1'b0;
        instr_ack = 1'b1;
        instr_in  = ins;
        tick();
        instr_ack = 1'b0;
        instr_in  = 16'h0;
    endtask

    // Serves one data transfer; counts cycles the request is held.
    task automatic do_mem(input int dly, input logic is_rd);
        int k = 0;
        int cnt = 0;
        while (!(mem_rd || mem_wr) && k < 50) begin
            tick();
            k++;
        end
        check("mem_addr_eq_a", {16'h0, mem_addr}, {16'h0, a_out});
        for (int i = 0; i <= dly; i++) begin
            if (is_rd ? mem_rd : mem_wr) cnt++;
            if (is_rd && mem_wr) begin
                checks++; errors++;
                $display("FAIL wrong_mem_req: mem_wr during read");
            end
            if (i == dly) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check("mem_req_cycles", cnt, dly + 1);
        check("mem_req_dropped", {31'h0, mem_rd | mem_wr}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; instr_ack = 1'b0; instr_in = 16'h0;
        mem_ack = 1'b0; mem_rdata = 16'h0; a_out = 16'h0; b_out = 16'h0;
        v = 1'b0; c = 1'b0; n = 1'b0; z = 1'b0;
        tick(); tick();

        // reset state
        check("rst_pc", {16'h0, pc}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_reqs", {28'h0, instr_req, mem_rd, mem_wr, load_en}, 32'h0);
        check("rst_selects", {16'h0, dest_sel, a_sel, b_sel, op_sel}, 32'h0);
        check("rst_const", {13'h0, const_sel, data_sel, 1'b0, const_out}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_no_req", {31'h0, instr_req}, 32'h0);

        start = 1'b1; tick(); start = 1'b0;

        // LDI r1,0x05 with same-cycle ack
        push_fetch(16'h0000);
        push_write(4'd1, 4'hF, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        do_fetch(16'hA105, 0, 1'b0);
        check("pc_after_ldi", {16'h0, pc}, 32'h1);

        // ALU 0x2 r3,r1,r2 with z=1 from the function unit
        z = 1'b1;
        push_fetch(16'h0001);
        push_write(4'd3, 4'h2, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd2);
        do_fetch(16'h2312, 0, 1'b0);
        tick();
        z = 1'b0;   // live Z now low; branch must use the latched flag

        // BR Z, -2 at pc 2: pc after fetch 3, taken -> 1
        push_fetch(16'h0002);
        do_fetch(16'hD1FE, 0, 1'b0);
        check("pc_br_exec", {16'h0, pc}, 32'h3);

        // LD r4,[r1] with ack delayed 3 cycles
        a_out = 16'h1234; mem_rdata = 16'hBEEF;
        push_fetch(16'h0001);
        push_write(4'd4, 4'hF, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        do_fetch(16'hB410, 0, 1'b0);
        do_mem(3, 1'b1);

        // ST [r5],r6 with instr ack delayed 2 and a stray mem_ack in FETCH
        a_out = 16'h00A0; b_out = 16'h5A5A;
        push_fetch(16'h0002);
        push_store(4'd5, 4'd6, 16'h00A0, 16'h5A5A);
        do_fetch(16'hC056, 2, 1'b1);
        do_mem(1, 1'b0);

        // JMP r7 to 0xFFFF, then HALT fetched from 0xFFFF
        a_out = 16'hFFFF;
        push_fetch(16'h0003);
        do_fetch(16'hE070, 0, 1'b0);
        push_fetch(16'hFFFF);
        do_fetch(16'hF000, 0, 1'b0);
        check("pc_wrap", {16'h0, pc}, 32'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            check("halt_state", {29'h0, halted, instr_req, mem_rd | mem_wr}, 32'h4);
            tick();
        end

        // resume, start an LD and reset in the middle of MEM
        start = 1'b1; tick(); start = 1'b0;
        push_fetch(16'h0000);
        do_fetch(16'hB410, 0, 1'b0);
        tick();
        check("mid_mem_rd", {31'h0, mem_rd}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_drops_rd", {28'h0, mem_rd, load_en, instr_req, halted}, 32'h0);
        check("rst_pc_mid", {16'h0, pc}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("idle_after_rst", {30'h0, instr_req, mem_rd}, 32'h0);

        // flags cleared by reset: BR Z not taken, BR !Z +2 taken
        start = 1'b1; tick(); start = 1'b0;
        push_fetch(16'h0000);
        do_fetch(16'hD110, 0, 1'b0);
        push_fetch(16'h0001);
        do_fetch(16'hD502, 0, 1'b0);
        push_fetch(16'h0004);
        do_fetch(16'hF000, 0, 1'b0);
        tick();
        check("final_halt", {31'h0, halted}, 32'h1);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
